// File: rtl/cskip_serial_add32.sv
// cskip_serial_add32
//   Multi-cycle WIDTH-bit adder. It pushes one SLICE-bit chunk per clock through
//   a single carry-skip slice and chains the carry through a register.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     in_valid   operand set a/b/cin is valid      in_ready   block can accept operands
//     a, b       WIDTH-bit operands                cin        carry into bit 0
//     out_valid  sum/cout are valid                out_ready  consumer takes the result
//     sum        a + b + cin mod 2^WIDTH           cout       carry out of bit WIDTH-1
//     busy       an add is in flight or its result is waiting
module cskip_serial_add32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [NSLICES-1:0][SLICE-1:0]   a_q, a_d;
    logic [NSLICES-1:0][SLICE-1:0]   b_q, b_d;
    logic [NSLICES-1:0][SLICE-1:0]   sum_q, sum_d;
    logic                            carry_q, carry_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [SLICE-1:0]                slice_sum;
    logic                            slice_cout;
    logic                            last_pass;

    // One carry-skip slice: ripple carry internally, but when every bit
    // propagates the carry-out is taken straight from the carry-in.
    function automatic logic [SLICE:0] cskip_slice(input logic [SLICE-1:0] x,
                                                   input logic [SLICE-1:0] y,
                                                   input logic             ci);
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] s;
        logic             c;
        p = x ^ y;
        g = x & y;
        c = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {((&p) ? ci : c), s};
    endfunction

    assign {slice_cout, slice_sum} = cskip_slice(a_q[idx_q], b_q[idx_q], carry_q);
    assign last_pass               = (idx_q == IDX_W'(NSLICES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_pass) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath next-state: operands are captured only on the accept edge, and
    // the sum register is written only by slice passes.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                idx_d        = last_pass ? '0 : idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // After the final pass the carry register holds the carry out of the top bit.
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_cskip_serial_add32.sv
module tb_cskip_serial_add32;

    localparam int WIDTH   = 32;
    localparam int SLICE   = 8;
    localparam int NSLICES = WIDTH / SLICE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              cin = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              in_ready;
    logic              out_valid;
    logic              cout;
    logic              busy;
    logic [WIDTH-1:0]  sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pop = 0;

    // Reference model: queue of a+b+cin (WIDTH+1 bits) per accepted operand set,
    // plus the accept time so out_valid can be expected NSLICES cycles later.
    logic [WIDTH:0] expq[$];
    bit             outstanding = 1'b0;
    int             acc_cyc = 0;

    cskip_serial_add32 #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare process: every falling edge, check handshake/status outputs and,
    // whenever out_valid is high, the result against the head of the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_sum", sum, 0);
                chk("rst_cout", cout, 0);
                chk("rst_busy", busy, 0);
                expq.delete();
                outstanding = 1'b0;
            end else begin
                chk("in_ready", in_ready, !outstanding);
                chk("busy", busy, outstanding);
                chk("out_valid", out_valid, outstanding && (cyc >= acc_cyc + NSLICES));
                if (out_valid) begin
                    if (expq.size() > 0) chk("result", {cout, sum}, expq[0]);
                    else chk("result_unexpected", 1, 0);
                end
                if (out_valid && out_ready && expq.size() > 0) begin
                    void'(expq.pop_front());
                    outstanding = 1'b0;
                    n_pop++;
                end
                if (in_valid && in_ready) begin
                    expq.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
                    outstanding = 1'b1;
                    acc_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
        bit ok;
        ok = 0;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("send_timeout", ok, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        chk("wait_valid_timeout", out_valid, 1);
    endtask

    task automatic release_result(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_add(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tc, input logic [WIDTH:0] exp);
        int lat;
        send(ta, tb_, tc);
        wait_valid(lat);
        chk({name, "_latency"}, lat, NSLICES);
        chk(name, {cout, sum}, exp);
        release_result(0);
    endtask

    initial begin
        int lat;
        int target;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_add("t1_a0", 32'h000000A0, 32'h000000A0, 1'b0, 33'h0_00000140);
        run_add("t2_mix", 32'h12345678, 32'h9ABCDEF0, 1'b0, 33'h0_ACF13568);
        run_add("t3_ovf", 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000);
        run_add("t3_cin", 32'h7FFFFFFF, 32'h00000000, 1'b1, 33'h0_80000000);
        run_add("t3_skipcin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);

        // Stall with out_ready low while in_valid/a/b wiggle.
        send(32'h11111111, 32'h22222222, 1'b0);
        wait_valid(lat);
        chk("t4_first", {cout, sum}, 33'h0_33333333);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom % 2);
            a = $urandom; b = $urandom; cin = 1'($urandom % 2);
            chk("t4_stall_sum", sum, 32'h33333333);
            chk("t4_stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        a = 32'h0000FFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_idle_after_hs", in_ready, 1);
        chk("t4_ovalid_drop", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_next_accepted", busy, 1);
        wait_valid(lat);
        chk("t4_next", {cout, sum}, 33'h0_00010000);
        release_result(0);

        // Asynchronous abort at slice index 2.
        send(32'hDEADBEEF, 32'h01234567, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("t5_async_in_ready", in_ready, 1);
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_sum", sum, 0);
        chk("t5_async_cout", cout, 0);
        chk("t5_async_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; chk("t5_no_ovalid", out_valid, 0); end
        run_add("t5_after", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_FFFFFFFE);

        // Random stream with random consumer stalls.
        target = n_pop + 20;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    send($urandom, $urandom, 1'($urandom % 2));
                    repeat ($urandom % 3) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int t = 0; t < 4000 && n_pop < target; t++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom % 2);
                end
                out_ready = 1'b0;
            end
        join
        chk("t6_count", n_pop, target);
        chk("drain", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
